uparc_rf_wb_arbiter: RTL and testbench

- Owns the single register-file write port (rd/rd_data, no separate write enable; rd=0 means no write).
- Merges three write sources: in-order pipeline writeback (wb), multiply/divide unit (md) and late load returns from the load/store unit (ls).
- Keeps a 32-entry scoreboard of destination registers reserved by long-latency operations and reports source-operand hazards to the decode-stage stall logic.

---
 rtl/uparc_rf_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_uparc_rf_wb_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uparc_rf_wb_arbiter.sv
// rtl/uparc_rf_wb_arbiter.sv - register-file write-port arbiter (wb/md/ls) with long-latency scoreboard
// Optional: `define UPARC_RF_SB_BYPASS_EN to mask busy when rd forwards the operand this cycle.

module uparc_rf_wb_arbiter #(
    parameter int REG_WIDTH   = 32,
    parameter int REGNO_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   wb_valid,
    input  logic [REGNO_WIDTH-1:0] wb_reg,
    input  logic [REG_WIDTH-1:0]   wb_data,
    input  logic                   md_valid,
    output logic                   md_ready,
    input  logic [REGNO_WIDTH-1:0] md_reg,
    input  logic [REG_WIDTH-1:0]   md_data,
    input  logic                   ls_valid,
    output logic                   ls_ready,
    input  logic [REGNO_WIDTH-1:0] ls_reg,
    input  logic [REG_WIDTH-1:0]   ls_data,
    input  logic                   rsv_valid,
    input  logic [REGNO_WIDTH-1:0] rsv_reg,
    input  logic [REGNO_WIDTH-1:0] rs,
    input  logic [REGNO_WIDTH-1:0] rt,
    output logic                   rs_busy,
    output logic                   rt_busy,
    output logic                   waw_hazard,
    output logic [REGNO_WIDTH-1:0] rd,
    output logic [REG_WIDTH-1:0]   rd_data
);

    localparam int SB_SIZE = 1 << REGNO_WIDTH;

    typedef enum logic {
        PTR_MD = 1'b0,
        PTR_LS = 1'b1
    } ptr_t;

    ptr_t                   r_ptr;
    ptr_t                   w_ptr_nxt;
    logic                   w_md_grant;
    logic                   w_ls_grant;
    logic [REGNO_WIDTH-1:0] r_rd;
    logic [REG_WIDTH-1:0]   r_rd_data;
    logic                   r_rd_sb;
    logic [SB_SIZE-1:0]     r_sb;
    logic [SB_SIZE-1:0]     w_sb_set;
    logic [SB_SIZE-1:0]     w_sb_clr;
    logic                   w_rs_fwd;
    logic                   w_rt_fwd;

    always_comb begin
        w_md_grant = 1'b0;
        w_ls_grant = 1'b0;
        w_ptr_nxt  = r_ptr;
        if (!wb_valid) begin
            w_md_grant = md_valid && (!ls_valid || r_ptr == PTR_MD);
            w_ls_grant = ls_valid && (!md_valid || r_ptr == PTR_LS);
        end
        if (w_md_grant)
            w_ptr_nxt = PTR_LS;
        else if (w_ls_grant)
            w_ptr_nxt = PTR_MD;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            r_ptr <= PTR_MD;
        else
            r_ptr <= w_ptr_nxt;
    end

    // r_rd_sb marks writes that retire a reservation; pipeline writebacks never do.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rd      <= '0;
            r_rd_data <= '0;
            r_rd_sb   <= 1'b0;
        end else if (wb_valid) begin
            r_rd      <= wb_reg;
            r_rd_data <= wb_data;
            r_rd_sb   <= 1'b0;
        end else if (w_md_grant) begin
            r_rd      <= md_reg;
            r_rd_data <= md_data;
            r_rd_sb   <= 1'b1;
        end else if (w_ls_grant) begin
            r_rd      <= ls_reg;
            r_rd_data <= ls_data;
            r_rd_sb   <= 1'b1;
        end else begin
            r_rd      <= '0;
            r_rd_sb   <= 1'b0;
        end
    end

    always_comb begin
        w_sb_set = '0;
        w_sb_clr = '0;
        if (rsv_valid && rsv_reg != '0)
            w_sb_set = SB_SIZE'(1) << rsv_reg;
        if (r_rd_sb)
            w_sb_clr = SB_SIZE'(1) << r_rd;
    end

    // Set is applied after clear so a fresh reservation survives a same-edge retire.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            r_sb <= '0;
        else
            r_sb <= (r_sb & ~w_sb_clr) | w_sb_set;
    end

`ifdef UPARC_RF_SB_BYPASS_EN
    assign w_rs_fwd = (r_rd == rs) && (r_rd != '0);
    assign w_rt_fwd = (r_rd == rt) && (r_rd != '0);
`else
    assign w_rs_fwd = 1'b0;
    assign w_rt_fwd = 1'b0;
`endif

    assign md_ready   = w_md_grant;
    assign ls_ready   = w_ls_grant;
    assign rs_busy    = r_sb[rs] && !w_rs_fwd;
    assign rt_busy    = r_sb[rt] && !w_rt_fwd;
    assign waw_hazard = wb_valid && r_sb[wb_reg];
    assign rd         = r_rd;
    assign rd_data    = r_rd_data;

endmodule

// File: tb/tb_uparc_rf_wb_arbiter.sv
// tb/tb_uparc_rf_wb_arbiter.sv - self-checking bench for uparc_rf_wb_arbiter against a reference model

module tb_uparc_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        wb_valid, md_valid, ls_valid, rsv_valid;
    logic [4:0]  wb_reg, md_reg, ls_reg, rsv_reg, rs, rt;
    logic [31:0] wb_data, md_data, ls_data;
    logic        md_ready, ls_ready, rs_busy, rt_busy, waw_hazard;
    logic [4:0]  rd;
    logic [31:0] rd_data;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] sb_m;
    logic [4:0]  rd_m;
    logic [31:0] rdd_m;
    bit          rd_retires_m;
    bit          last_md_m;
    bit          g_md, g_ls;

    always #5 clk = ~clk;

    uparc_rf_wb_arbiter #(.REG_WIDTH(32), .REGNO_WIDTH(5)) dut (
        .clk(clk), .nrst(nrst),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
        .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_reg(ls_reg), .ls_data(ls_data),
        .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
        .rs(rs), .rt(rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .waw_hazard(waw_hazard), .rd(rd), .rd_data(rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_busy(input logic [4:0] r);
        bit b;
        b = (r != 5'd0) && sb_m[r];
`ifdef UPARC_RF_SB_BYPASS_EN
        if (rd_m == r && rd_m != 5'd0) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic model_reset();
        sb_m = '0; rd_m = '0; rdd_m = '0; rd_retires_m = 1'b0; last_md_m = 1'b0;
        g_md = 1'b0; g_ls = 1'b0;
    endtask

    task automatic idle();
        wb_valid = 0; md_valid = 0; ls_valid = 0; rsv_valid = 0;
        wb_reg = 0; md_reg = 0; ls_reg = 0; rsv_reg = 0;
        wb_data = 0; md_data = 0; ls_data = 0;
    endtask

    // Called at a negedge with inputs already driven; returns at the following negedge.
    task automatic step();
        #1;
        g_md = !wb_valid && md_valid && (!ls_valid || !last_md_m);
        g_ls = !wb_valid && ls_valid && (!md_valid || last_md_m);
        chk("md_ready", md_ready, g_md);
        chk("ls_ready", ls_ready, g_ls);
        chk("rs_busy", rs_busy, exp_busy(rs));
        chk("rt_busy", rt_busy, exp_busy(rt));
        chk("waw_hazard", waw_hazard, wb_valid && sb_m[wb_reg]);
        @(posedge clk);
        if (rd_retires_m) sb_m[rd_m] = 1'b0;
        if (rsv_valid && rsv_reg != 5'd0) sb_m[rsv_reg] = 1'b1;
        if (wb_valid) begin
            rd_m = wb_reg; rdd_m = wb_data; rd_retires_m = 1'b0;
        end else if (g_md) begin
            rd_m = md_reg; rdd_m = md_data; rd_retires_m = 1'b1; last_md_m = 1'b1;
        end else if (g_ls) begin
            rd_m = ls_reg; rdd_m = ls_data; rd_retires_m = 1'b1; last_md_m = 1'b0;
        end else begin
            rd_m = 5'd0; rd_retires_m = 1'b0;
        end
        @(negedge clk);
        chk("rd", rd, rd_m);
        chk("rd_data", rd_data, rdd_m);
    endtask

    initial begin
        nrst = 1'b0;
        idle();
        rs = 0; rt = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd", rd, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_md_ready", md_ready, 0);
        chk("rst_ls_ready", ls_ready, 0);
        chk("rst_rs_busy", rs_busy, 0);
        chk("rst_waw", waw_hazard, 0);
        nrst = 1'b1;
        @(negedge clk);

        // wb priority over held md/ls, then md before ls
        wb_valid = 1; md_valid = 1; md_reg = 8; md_data = 32'h8888_0008;
        ls_valid = 1; ls_reg = 9; ls_data = 32'h9999_0009;
        for (int i = 0; i < 3; i++) begin
            wb_reg = 5'(i + 1); wb_data = $urandom;
            step();
            chk("t3_wb_rd", rd, i + 1);
        end
        wb_valid = 0;
        step();
        chk("t3_md_rd", rd, 8);
        md_valid = 0;
        step();
        chk("t3_ls_rd", rd, 9);
        ls_valid = 0;

        // reserve 5, retire it through md
        rsv_valid = 1; rsv_reg = 5;
        step();
        rsv_valid = 0; rs = 5; rt = 0;
        step();
        chk("t1_rs_busy", rs_busy, 1);
        chk("t1_rt_busy", rt_busy, 0);
        md_valid = 1; md_reg = 5; md_data = 32'h1234_5678;
        step();
        md_valid = 0;
        chk("t2_rd", rd, 5);
        chk("t2_rd_data", rd_data, 32'h1234_5678);
`ifdef UPARC_RF_SB_BYPASS_EN
        chk("t2_rs_busy_fwd", rs_busy, 0);
`else
        chk("t2_rs_busy_fwd", rs_busy, 1);
`endif
        step();
        chk("t2_rd_after", rd, 0);
        chk("t2_rs_busy_after", rs_busy, 0);

        // md and ls contending continuously
        md_valid = 1; md_reg = 10; md_data = $urandom;
        ls_valid = 1; ls_reg = 11; ls_data = $urandom;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t4_nobubble", rd != 5'd0, 1);
            if (g_md) begin md_reg = 5'($urandom_range(10, 15)); md_data = $urandom; end
            if (g_ls) begin ls_reg = 5'($urandom_range(10, 15)); ls_data = $urandom; end
        end
        idle();

        // R0 handling and WAW
        ls_valid = 1; ls_reg = 0; ls_data = 32'hdead_beef;
        step();
        ls_valid = 0;
        chk("t5_r0_rd", rd, 0);
        rsv_valid = 1; rsv_reg = 0; rs = 0; rt = 0;
        step();
        rsv_reg = 7;
        step();
        rsv_valid = 0; wb_valid = 1; wb_reg = 7; wb_data = 32'h0707_0707;
        step();
        chk("t5_waw", waw_hazard, 1);
        chk("t5_wb_rd", rd, 7);
        wb_valid = 0;

        // same-edge set/clear on reg 4, then asynchronous reset mid-request
        rsv_valid = 1; rsv_reg = 4;
        step();
        rsv_valid = 0; md_valid = 1; md_reg = 4; md_data = 32'h4444_4444;
        step();
        md_valid = 0; rsv_valid = 1; rsv_reg = 4; rs = 4; rt = 7;
        step();
        rsv_valid = 0;
        step();
        chk("t6_rs_busy_kept", rs_busy, 1);
        md_valid = 1; md_reg = 9; md_data = $urandom;
        ls_valid = 1; ls_reg = 3; ls_data = $urandom;
        @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        chk("t6_rst_rd", rd, 0);
        chk("t6_rst_rd_data", rd_data, 0);
        chk("t6_rst_rs_busy", rs_busy, 0);
        chk("t6_rst_rt_busy", rt_busy, 0);
        idle();
        model_reset();
        @(negedge clk);
        nrst = 1'b1;

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            wb_valid = ($urandom_range(0, 2) == 0);
            wb_reg   = 5'($urandom_range(0, 15));
            wb_data  = $urandom;
            if (!md_valid || g_md) begin
                md_valid = $urandom_range(0, 1) == 1;
                md_reg   = 5'($urandom_range(0, 15));
                md_data  = $urandom;
            end
            if (!ls_valid || g_ls) begin
                ls_valid = $urandom_range(0, 1) == 1;
                ls_reg   = 5'($urandom_range(0, 15));
                ls_data  = $urandom;
            end
            rsv_valid = ($urandom_range(0, 3) == 0);
            rsv_reg   = 5'($urandom_range(0, 15));
            rs        = 5'($urandom_range(0, 15));
            rt        = 5'($urandom_range(0, 15));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
